life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 SHALL have parameters: X, default 8, board width; Y, default 8, board height; LOG2X, default 3, cursor_x width; LOG2Y, default 3, cursor_y width; GEN_W, default 16, generation counter width.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs: btn_run 1 (toggle run/pause pulse); btn_step 1 (single-generation pulse); btn_flip 1 (flip cell under cursor); btn_up/btn_down/btn_left/btn_right 1 each (cursor moves). All are single-cycle, pre-debounced, clk-synchronous.
REQ-004 SHALL have input rate 8, the number of idle board rotations between generations in run mode.
REQ-005 SHALL have outputs: nxt_bit 1 (sweep active, to datapath); cell_flip 1 (flip strobe); cursor_x LOG2X; cursor_y LOG2Y; bit_pos LOG2X+LOG2Y (rotation phase); gen_count GEN_W; running 1; busy 1 (sweep in progress).

Function
REQ-006 SHALL increment bit_pos every cycle out of reset, wrapping from X*Y-1 to 0; phase 0 is the home rotation alignment.
REQ-007 SHALL implement FSM states IDLE, WAIT and SWEEP.
REQ-008 IDLE: on btn_run, SHALL set running=1 and enter WAIT with wait counter=0. On btn_step while running=0, SHALL latch step_pend.
REQ-009 SHALL enter SWEEP from IDLE (step_pend) or WAIT (wait counter==rate) only on the cycle bit_pos==X*Y-1, so that the sweep covers bit_pos 0..X*Y-1.
REQ-010 SWEEP: SHALL assert nxt_bit and busy for exactly X*Y consecutive cycles, then exit to WAIT if running=1, else to IDLE; on exit, SHALL increment gen_count modulo 2^GEN_W and clear step_pend.
REQ-011 WAIT: SHALL increment the wait counter each time bit_pos wraps to 0; rate=0 SHALL give back-to-back sweeps, with no gap cycle.
REQ-012 On btn_run while running=1, SHALL clear running; an active sweep SHALL complete, then go to IDLE; in WAIT, SHALL go to IDLE immediately.
REQ-013 btn_run and btn_step in the same cycle: btn_run SHALL take effect and btn_step SHALL be dropped. btn_step while running=1 SHALL be ignored.
REQ-014 Cursor moves SHALL wrap: right/left on cursor_x modulo X, down/up on cursor_y modulo Y; opposite buttons in the same cycle SHALL cancel.
REQ-015 btn_flip SHALL latch flip_pend. cell_flip SHALL pulse for one cycle when flip_pend=1, state!=SWEEP and bit_pos==0, and SHALL never pulse while nxt_bit=1. The pulse SHALL clear flip_pend.
REQ-016 A cursor move while flip_pend=1 SHALL NOT change the flipped cell, because the flip coordinates are latched at btn_flip; cursor_x/cursor_y SHALL output those latched coordinates during the cell_flip cycle.
REQ-017 A second btn_flip while flip_pend=1 SHALL be ignored.
REQ-018 A flip pending when a sweep would start SHALL be issued first: the SWEEP start SHALL defer one full rotation.

Reset
REQ-019 reset low SHALL asynchronously force: state=IDLE, bit_pos=0, gen_count=0, cursor 0/0, running=0, nxt_bit=0, cell_flip=0, busy=0, all pending flags and counters 0.
REQ-020 Reset mid-sweep SHALL drop nxt_bit within the same cycle, and SHALL NOT increment gen_count.

Structure
REQ-021 A shared package life_pkg SHALL hold the FSM state enum and localparams CELLS=X*Y and POS_W=LOG2X+LOG2Y.
REQ-022 Cursor wrap logic SHALL live in one sub-module, life_cursor; the FSM, the counters and the flip logic SHALL remain in life_ctrl.

Verification (X=Y=8)
REQ-023 Reset, then btn_step at bit_pos=10 -> nxt_bit high for bit_pos 0..63 of the next rotation, 64 cycles exactly; gen_count=1; IDLE.
REQ-024 btn_run with rate=2 -> sweeps separated by exactly 2 full rotations (128 idle cycles); gen_count increments once per sweep.
REQ-025 Cursor at (7,7), btn_right then btn_down -> cursor (0,0); btn_left and btn_right in the same cycle -> no change.
REQ-026 btn_flip during a sweep at cursor (3,5), then btn_right -> cell_flip pulses once, at the first bit_pos==0 after the sweep with running=0, with cursor_x=3, cursor_y=5.
REQ-027 Reset asserted at sweep cycle 30 -> nxt_bit=0 immediately; gen_count=0; bit_pos restarts at 0 after release.
REQ-028 btn_run and btn_step in the same cycle while idle -> running=1, step_pend=0, first sweep after 0 idle rotations when rate=0.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game-of-Life control slice.
// Holds the sequencer state encoding and the default board geometry.
// CELLS and POS_W describe the default 8x8 board. Modules recompute
// both values from their own parameters, so overriding X/Y stays consistent.
package life_pkg;

    localparam int X_DEF     = 8;
    localparam int Y_DEF     = 8;
    localparam int LOG2X_DEF = 3;
    localparam int LOG2Y_DEF = 3;
    localparam int GEN_W_DEF = 16;

    localparam int CELLS = X_DEF * Y_DEF;
    localparam int POS_W = LOG2X_DEF + LOG2Y_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

endpackage

// File: rtl/life_cursor.sv
// life_cursor: edit cursor for the life board.
// The cursor wraps modulo X horizontally and modulo Y vertically.
//   clk, reset             clock, async active-low reset
//   btn_up/down/left/right single-cycle move pulses; opposite pairs cancel
//   cur_x, cur_y           current cursor position
module life_cursor #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [LOG2X-1:0] cur_x,
    output logic [LOG2Y-1:0] cur_y
);

    localparam logic [LOG2X-1:0] X_MAX = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] Y_MAX = LOG2Y'(Y - 1);

    logic [LOG2X-1:0] x_q, x_d;
    logic [LOG2Y-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (btn_right && !btn_left)
            x_d = (x_q == X_MAX) ? '0 : x_q + 1'b1;
        else if (btn_left && !btn_right)
            x_d = (x_q == '0) ? X_MAX : x_q - 1'b1;
        if (btn_down && !btn_up)
            y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        else if (btn_up && !btn_down)
            y_d = (y_q == '0) ? Y_MAX : y_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign cur_x = x_q;
    assign cur_y = y_q;

endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: run/step/edit sequencer for a recirculating life board.
// bit_pos tracks the rotation phase of the board shift register. A
// generation is one full-rotation sweep aligned to phase 0.
//   clk, reset              clock, async active-low reset
//   btn_run/step/flip       run toggle, single step, flip cell under cursor
//   btn_up/down/left/right  cursor moves
//   rate                    idle rotations between generations while running
//   nxt_bit, busy           high for the X*Y cycles of a sweep
//   cell_flip               one-cycle flip strobe at phase 0, never in a sweep
//   cursor_x, cursor_y      cursor, or latched flip target during cell_flip
//   bit_pos                 rotation phase
//   gen_count               completed generations
//   running                 run mode flag
module life_ctrl
    import life_pkg::*;
#(
    parameter int X     = X_DEF,
    parameter int Y     = Y_DEF,
    parameter int LOG2X = LOG2X_DEF,
    parameter int LOG2Y = LOG2Y_DEF,
    parameter int GEN_W = GEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_run,
    input  logic                   btn_step,
    input  logic                   btn_flip,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic [7:0]             rate,
    output logic                   nxt_bit,
    output logic                   cell_flip,
    output logic [LOG2X-1:0]       cursor_x,
    output logic [LOG2Y-1:0]       cursor_y,
    output logic [LOG2X+LOG2Y-1:0] bit_pos,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   running,
    output logic                   busy
);

    localparam int NCELL = X * Y;
    localparam int PW    = LOG2X + LOG2Y;

    state_e           state_q, state_d;
    logic [PW-1:0]    bit_pos_q, bit_pos_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             running_q, running_d;
    logic             step_pend_q, step_pend_d;
    logic             flip_pend_q, flip_pend_d;
    logic [LOG2X-1:0] flip_x_q, flip_x_d;
    logic [LOG2Y-1:0] flip_y_q, flip_y_d;
    logic [LOG2X-1:0] cur_x;
    logic [LOG2Y-1:0] cur_y;
    logic             last;
    logic             flip_fire;
    logic             run_now;

    life_cursor #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y)) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .cur_x    (cur_x),
        .cur_y    (cur_y)
    );

    always_comb begin
        last      = (bit_pos_q == PW'(NCELL - 1));
        bit_pos_d = last ? '0 : bit_pos_q + 1'b1;
        flip_fire = flip_pend_q && (state_q != ST_SWEEP) && (bit_pos_q == '0);
        run_now   = running_q ^ btn_run;

        // The flip target is captured at the button press, so later cursor
        // moves cannot retarget a pending flip.
        flip_pend_d = flip_pend_q;
        flip_x_d    = flip_x_q;
        flip_y_d    = flip_y_q;
        if (flip_fire) begin
            flip_pend_d = 1'b0;
        end else if (btn_flip && !flip_pend_q) begin
            flip_pend_d = 1'b1;
            flip_x_d    = cur_x;
            flip_y_d    = cur_y;
        end

        state_d     = state_q;
        running_d   = running_q;
        step_pend_d = step_pend_q;
        wait_cnt_d  = wait_cnt_q;
        gen_d       = gen_q;

        // Sweeps start on the last phase so they span phases 0..NCELL-1.
        // A pending flip holds the start off by one rotation so the flip
        // strobe at phase 0 is issued first.
        case (state_q)
            ST_IDLE: begin
                // running is always clear here, so btn_step is accepted
                if (btn_run) begin
                    running_d   = 1'b1;
                    state_d     = ST_WAIT;
                    wait_cnt_d  = '0;
                    step_pend_d = 1'b0;
                end else begin
                    if (btn_step)
                        step_pend_d = 1'b1;
                    if (step_pend_q && last && !flip_pend_q)
                        state_d = ST_SWEEP;
                end
            end
            ST_WAIT: begin
                if (btn_run) begin
                    running_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (last) begin
                    if (wait_cnt_q >= rate) begin
                        if (!flip_pend_q)
                            state_d = ST_SWEEP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_SWEEP: begin
                running_d = run_now;
                if (last) begin
                    gen_d       = gen_q + 1'b1;
                    step_pend_d = 1'b0;
                    if (!run_now) begin
                        state_d = ST_IDLE;
                    end else if (rate == 8'd0 && !flip_pend_q) begin
                        state_d = ST_SWEEP;
                    end else begin
                        // the exit edge is itself a wrap to phase 0
                        state_d    = ST_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_pos_q   <= '0;
            gen_q       <= '0;
            wait_cnt_q  <= '0;
            running_q   <= 1'b0;
            step_pend_q <= 1'b0;
            flip_pend_q <= 1'b0;
            flip_x_q    <= '0;
            flip_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_pos_q   <= bit_pos_d;
            gen_q       <= gen_d;
            wait_cnt_q  <= wait_cnt_d;
            running_q   <= running_d;
            step_pend_q <= step_pend_d;
            flip_pend_q <= flip_pend_d;
            flip_x_q    <= flip_x_d;
            flip_y_q    <= flip_y_d;
        end
    end

    // Decoded straight from state so reset drops them without a clock edge.
    assign nxt_bit   = (state_q == ST_SWEEP);
    assign busy      = (state_q == ST_SWEEP);
    assign cell_flip = flip_fire;
    assign cursor_x  = flip_fire ? flip_x_q : cur_x;
    assign cursor_y  = flip_fire ? flip_y_q : cur_y;
    assign bit_pos   = bit_pos_q;
    assign gen_count = gen_q;
    assign running   = running_q;

endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: directed checks of life_ctrl on the default 8x8 board.
module tb_life_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_run, btn_step, btn_flip;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [7:0]  rate;
    logic        nxt_bit, cell_flip, running, busy;
    logic [2:0]  cursor_x, cursor_y;
    logic [5:0]  bit_pos;
    logic [15:0] gen_count;

    int n_chk = 0;
    int n_err = 0;
    int overlap = 0;

    localparam logic [6:0] B_RUN   = 7'b1000000;
    localparam logic [6:0] B_STEP  = 7'b0100000;
    localparam logic [6:0] B_FLIP  = 7'b0010000;
    localparam logic [6:0] B_UP    = 7'b0001000;
    localparam logic [6:0] B_DOWN  = 7'b0000100;
    localparam logic [6:0] B_LEFT  = 7'b0000010;
    localparam logic [6:0] B_RIGHT = 7'b0000001;

    life_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_flip (btn_flip),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .rate     (rate),
        .nxt_bit  (nxt_bit),
        .cell_flip(cell_flip),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .bit_pos  (bit_pos),
        .gen_count(gen_count),
        .running  (running),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && cell_flip && nxt_bit) overlap++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [6:0] m);
        {btn_run, btn_step, btn_flip, btn_up, btn_down, btn_left, btn_right} = m;
        @(negedge clk);
        {btn_run, btn_step, btn_flip, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (int'(bit_pos) != p && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pos_reached", int'(bit_pos), p);
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (!nxt_bit && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!nxt_bit) chk("nxt_rise_timeout", int'(nxt_bit), 1);
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (nxt_bit && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!nxt_bit && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, g0, hits;
        reset = 1'b0;
        rate  = 8'd0;
        {btn_run, btn_step, btn_flip, btn_up, btn_down, btn_left, btn_right} = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_bit_pos", int'(bit_pos), 0);
        chk("rst_gen", int'(gen_count), 0);
        chk("rst_cursor_x", int'(cursor_x), 0);
        chk("rst_cursor_y", int'(cursor_y), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_nxt_bit", int'(nxt_bit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cell_flip", int'(cell_flip), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("bit_pos_first_inc", int'(bit_pos), 1);

        // single step at phase 10: sweep covers the next full rotation
        wait_pos(10);
        press(B_STEP);
        wait_rise(n);
        chk("step_delay", n, 53);
        chk("step_start_pos", int'(bit_pos), 0);
        chk("step_busy", int'(busy), 1);
        count_high(n);
        chk("step_sweep_len", n, 64);
        chk("step_end_pos", int'(bit_pos), 0);
        chk("step_gen", int'(gen_count), 1);
        chk("step_idle_busy", int'(busy), 0);

        // run with rate=2: two idle rotations between sweeps
        rate = 8'd2;
        press(B_RUN);
        chk("run_on", int'(running), 1);
        wait_rise(n);
        count_high(n);
        chk("run_sweep1_len", n, 64);
        chk("run_gen1", int'(gen_count), 2);
        count_low(n);
        chk("run_gap", n, 128);
        count_high(n);
        chk("run_sweep2_len", n, 64);
        chk("run_gen2", int'(gen_count), 3);
        press(B_RUN);
        chk("run_off_in_wait", int'(running), 0);
        chk("run_off_busy", int'(busy), 0);
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            if (nxt_bit) hits++;
            @(negedge clk);
        end
        chk("no_sweep_after_stop", hits, 0);

        // run+step together, rate=0: sweep at next phase 0, back-to-back
        rate = 8'd0;
        wait_pos(20);
        press(B_RUN | B_STEP);
        chk("run_step_running", int'(running), 1);
        wait_rise(n);
        chk("run_step_delay", n, 43);
        g0 = int'(gen_count);
        n = 0;
        while (nxt_bit && n < 1000) begin
            n++;
            btn_run = (n == 100);
            @(negedge clk);
        end
        btn_run = 1'b0;
        chk("b2b_high_len", n, 128);
        chk("b2b_gen", int'(gen_count), g0 + 2);
        chk("b2b_stopped", int'(running), 0);
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            if (nxt_bit) hits++;
            @(negedge clk);
        end
        chk("no_step_left", hits, 0);

        // cursor wrap and cancel
        press(B_LEFT);
        chk("cur_left_wrap", int'(cursor_x), 7);
        press(B_RIGHT);
        chk("cur_right_back", int'(cursor_x), 0);
        for (int i = 0; i < 7; i++) press(B_RIGHT);
        for (int i = 0; i < 7; i++) press(B_DOWN);
        chk("cur_at_7_x", int'(cursor_x), 7);
        chk("cur_at_7_y", int'(cursor_y), 7);
        press(B_RIGHT);
        press(B_DOWN);
        chk("cur_wrap_x", int'(cursor_x), 0);
        chk("cur_wrap_y", int'(cursor_y), 0);
        press(B_LEFT | B_RIGHT);
        chk("cur_lr_cancel", int'(cursor_x), 0);
        press(B_UP | B_DOWN);
        chk("cur_ud_cancel", int'(cursor_y), 0);
        press(B_UP);
        chk("cur_up_wrap", int'(cursor_y), 7);
        press(B_DOWN);
        chk("cur_down_back", int'(cursor_y), 0);

        // flip during sweep at (3,5), then move and re-flip
        for (int i = 0; i < 3; i++) press(B_RIGHT);
        for (int i = 0; i < 5; i++) press(B_DOWN);
        press(B_STEP);
        wait_rise(n);
        repeat (5) @(negedge clk);
        press(B_FLIP);
        press(B_RIGHT);
        press(B_FLIP);
        chk("flip_live_cursor", int'(cursor_x), 4);
        count_high(n);
        chk("flip_pulse", int'(cell_flip), 1);
        chk("flip_pos", int'(bit_pos), 0);
        chk("flip_x", int'(cursor_x), 3);
        chk("flip_y", int'(cursor_y), 5);
        @(negedge clk);
        chk("flip_one_cycle", int'(cell_flip), 0);
        chk("flip_after_x", int'(cursor_x), 4);
        hits = 0;
        for (int i = 0; i < 130; i++) begin
            if (cell_flip) hits++;
            @(negedge clk);
        end
        chk("flip_second_ignored", hits, 0);

        // pending flip defers a stepped sweep by one rotation
        wait_pos(10);
        press(B_FLIP);
        press(B_STEP);
        n = 0;
        while (!cell_flip && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("defer_flip_delay", n, 52);
        chk("defer_flip_no_nxt", int'(nxt_bit), 0);
        wait_rise(n);
        chk("defer_sweep_delay", n, 64);
        count_high(n);
        chk("defer_sweep_len", n, 64);

        // reset in the middle of a sweep
        press(B_STEP);
        wait_rise(n);
        repeat (30) @(negedge clk);
        chk("pre_rst_nxt", int'(nxt_bit), 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_nxt", int'(nxt_bit), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_gen", int'(gen_count), 0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_rel_pos0", int'(bit_pos), 0);
        @(negedge clk);
        chk("rst_rel_pos1", int'(bit_pos), 1);
        chk("rst_rel_gen", int'(gen_count), 0);

        chk("flip_nxt_exclusive", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
